// File: rtl/empaquetador_2a8bits.sv
// Packs four valid 2-bit pairs into one byte and queues finished bytes in a
// two-entry FIFO with a sticky overflow flag for words that found no room.
module empaquetador_2a8bits #(
   parameter int MSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [1:0] data_in,
   input  logic       pop,
   output logic       valid_out,
   output logic [7:0] data_out,
   output logic [1:0] occupancy,
   output logic       overflow_err
);

   // Drops a pair into its slot; slot order depends on MSB_FIRST.
   function automatic logic [7:0] place_pair(input logic [7:0] word,
                                             input logic [1:0] idx,
                                             input logic [1:0] pair);
      logic [7:0] res;
      logic [2:0] lsb;
      res = word;
      if (MSB_FIRST != 0) lsb = 3'd6 - {idx, 1'b0};
      else                lsb = {idx, 1'b0};
      res[lsb +: 2] = pair;
      return res;
   endfunction

   logic [1:0] pair_cnt_p0;
   logic [7:0] partial_p0;

   logic [7:0] mem_p1 [2];
   logic       rd_ptr_p1;
   logic       wr_ptr_p1;
   logic [1:0] count_p1;
   logic       ovf_p1;

   logic       push;
   logic       pop_ok;
   logic       accept;
   logic       drop;
   logic [7:0] word_in;

   always_comb begin
      word_in = place_pair(partial_p0, pair_cnt_p0, data_in);
      push    = valid_in && (pair_cnt_p0 == 2'd3);
      pop_ok  = pop && (count_p1 != 2'd0);
      // A full FIFO still takes a word when the head leaves on the same edge.
      accept  = push && ((count_p1 != 2'd2) || pop_ok);
      drop    = push && !accept;
   end

   // Stage 0: pair accumulation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pair_cnt_p0 <= 2'd0;
         partial_p0  <= 8'h00;
      end else if (valid_in) begin
         pair_cnt_p0 <= pair_cnt_p0 + 2'd1;
         if (push) partial_p0 <= 8'h00;
         else      partial_p0 <= word_in;
      end
   end

   // Stage 1: output FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_p1[0] <= 8'h00;
         mem_p1[1] <= 8'h00;
         rd_ptr_p1 <= 1'b0;
         wr_ptr_p1 <= 1'b0;
         count_p1  <= 2'd0;
         ovf_p1    <= 1'b0;
      end else begin
         if (accept) begin
            mem_p1[wr_ptr_p1] <= word_in;
            wr_ptr_p1         <= ~wr_ptr_p1;
         end
         if (pop_ok) rd_ptr_p1 <= ~rd_ptr_p1;
         if (accept && !pop_ok)      count_p1 <= count_p1 + 2'd1;
         else if (pop_ok && !accept) count_p1 <= count_p1 - 2'd1;
         if (drop) ovf_p1 <= 1'b1;
      end
   end

   always_comb begin
      valid_out    = (count_p1 != 2'd0);
      data_out     = valid_out ? mem_p1[rd_ptr_p1] : 8'h00;
      occupancy    = count_p1;
      overflow_err = ovf_p1;
   end

endmodule
